// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch FIFO between I-cache and decode, with branch flush
// and a refill filter that drops stale cache beats until the branch target arrives.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fetch_valid,
    input  logic [WIDTH-1:0]         fetch_instr,
    input  logic [WIDTH-1:0]         fetch_pc,
    output logic                     fetch_ready,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         flush_target,
    output logic                     id_valid,
    output logic [WIDTH-1:0]         id_instr,
    output logic [WIDTH-1:0]         id_pc,
    input  logic                     id_stall,
    output logic [$clog2(DEPTH):0]   count,
    output logic [15:0]              discard_cnt
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic {RUN, REFILL} state_e;
    state_e             state_q, state_d;
    logic [AW-1:0]      rd_q, rd_d, wr_q, wr_d;
    logic [AW:0]        count_q, count_d;
    logic [WIDTH-1:0]   target_q, target_d;
    logic [15:0]        disc_q, disc_d;
    logic [WIDTH-1:0]   instr_mem [DEPTH];
    logic [WIDTH-1:0]   pc_mem [DEPTH];
    logic               push, pop, match, drop;
    assign fetch_ready = count_q != (AW+1)'(DEPTH);
    assign id_valid    = count_q != '0;
    assign id_instr    = id_valid ? instr_mem[rd_q] : '0;
    assign id_pc       = id_valid ? pc_mem[rd_q] : '0;
    assign count       = count_q;
    assign discard_cnt = disc_q;
    assign match = fetch_pc == target_q;
    // flush overrides any push or pop in its cycle
    assign push  = fetch_valid & fetch_ready & (state_q == RUN | match) & ~flush;
    assign drop  = fetch_valid & fetch_ready & (state_q == REFILL) & ~match & ~flush;
    assign pop   = id_valid & ~id_stall & ~flush;
    always_comb begin
        rd_d     = flush ? '0 : rd_q + AW'(pop);
        wr_d     = flush ? '0 : wr_q + AW'(push);
        count_d  = flush ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);
        target_d = flush ? flush_target : target_q;
        state_d  = flush ? REFILL : (push ? RUN : state_q);
        disc_d   = (drop && disc_q != 16'hFFFF) ? disc_q + 16'd1 : disc_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= RUN;
            rd_q     <= '0;
            wr_q     <= '0;
            count_q  <= '0;
            target_q <= '0;
            disc_q   <= '0;
        end else begin
            state_q  <= state_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            count_q  <= count_d;
            target_q <= target_d;
            disc_q   <= disc_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_q] <= fetch_instr;
            pc_mem[wr_q]    <= fetch_pc;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed and randomized checks of fetch_queue against a queue-based model.
module tb_fetch_queue;
    localparam int DEPTH = 4;
    localparam int WIDTH = 16;
    logic clk = 0, rst = 1;
    logic fetch_valid = 0, flush = 0, id_stall = 0;
    logic [WIDTH-1:0] fetch_instr = 0, fetch_pc = 0, flush_target = 0;
    logic fetch_ready, id_valid;
    logic [WIDTH-1:0] id_instr, id_pc;
    logic [2:0] count;
    logic [15:0] discard_cnt;
    int checks = 0, failures = 0;

    fetch_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .fetch_valid(fetch_valid), .fetch_instr(fetch_instr),
        .fetch_pc(fetch_pc), .fetch_ready(fetch_ready), .flush(flush),
        .flush_target(flush_target), .id_valid(id_valid), .id_instr(id_instr),
        .id_pc(id_pc), .id_stall(id_stall), .count(count), .discard_cnt(discard_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of {instr, pc} plus refill flag, target and drop counter.
    logic [31:0] mq[$];
    bit          m_refill = 0;
    logic [15:0] m_target = 0, m_disc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] h;
        h = mq.size() != 0 ? mq[0] : 32'h0;
        chk({tag, ".count"}, 32'(count), 32'(mq.size()));
        chk({tag, ".ready"}, 32'(fetch_ready), 32'(mq.size() != DEPTH));
        chk({tag, ".id_valid"}, 32'(id_valid), 32'(mq.size() != 0));
        chk({tag, ".id_instr"}, 32'(id_instr), {16'h0, h[31:16]});
        chk({tag, ".id_pc"}, 32'(id_pc), {16'h0, h[15:0]});
        chk({tag, ".discard"}, 32'(discard_cnt), 32'(m_disc));
    endtask

    // One clock: drive inputs, advance the model across the edge, compare #1 later.
    task automatic step(input string tag, input bit fv, input logic [15:0] pc,
                        input logic [15:0] ins, input bit fl, input logic [15:0] tgt,
                        input bit st);
        bit ready, hit;
        fetch_valid = fv; fetch_pc = pc; fetch_instr = ins;
        flush = fl; flush_target = tgt; id_stall = st;
        @(posedge clk);
        ready = mq.size() != DEPTH;
        hit = !m_refill || pc == m_target;
        if (fl) begin
            mq.delete();
            m_refill = 1;
            m_target = tgt;
        end else begin
            if (mq.size() != 0 && !st) void'(mq.pop_front());
            if (fv && ready && hit) begin
                mq.push_back({ins, pc});
                m_refill = 0;
            end else if (fv && ready && m_disc != 16'hFFFF) m_disc++;
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [15:0] pcn;
        bit fl;
        #12 rst = 0;
        #1 check_all("reset");
        chk("reset.ready_const", 32'(fetch_ready), 32'h1);
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++)
            step("stream", 1, 16'(i), 16'h1000 + 16'(i), 0, 0, 0);
        step("stream_tail", 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++)
            step("stall_fill", 1, 16'(i), 16'h1000 + 16'(i), 0, 0, 1);
        chk("full_ready_const", 32'(fetch_ready), 32'h0);
        chk("full_head_const", 32'(id_pc), 32'h0);
        for (int i = 0; i < 5; i++)
            step("drain", 0, 0, 0, 0, 0, 0);
        pcn = 16'h0100;
        for (int i = 0; i < 3 * DEPTH * 5; i++) begin
            fl = ($urandom_range(0, 15) == 0);
            step("rand", fl ? 1'b0 : 1'($urandom), pcn, 16'($urandom), fl, pcn + 16'd2,
                 1'($urandom));
            if (fetch_valid && !fl) pcn++;
        end
        for (int i = 0; i < 6; i++)
            step("rand_drain", 1, pcn + 16'(i), 16'hAA00 + 16'(i), 0, 0, 0);
        for (int i = 0; i < 6; i++)
            step("idle", 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            step("pre_flush", 1, 16'(4 + i), 16'h2000 + 16'(i), 0, 0, 1);
        step("flush", 1, 16'h7, 16'h2007, 1, 16'h0040, 0);
        chk("flush_count_const", 32'(count), 32'h0);
        chk("flush_valid_const", 32'(id_valid), 32'h0);
        m_disc = discard_cnt == m_disc ? m_disc : m_disc;
        step("drop8", 1, 16'h8, 16'h2008, 0, 0, 0);
        step("drop9", 1, 16'h9, 16'h2009, 0, 0, 0);
        step("hit40", 1, 16'h40, 16'h2040, 0, 0, 0);
        chk("hit40_pc_const", 32'(id_pc), 32'h40);
        step("after40", 0, 0, 0, 0, 0, 0);
        step("flush10", 0, 0, 0, 1, 16'h0010, 0);
        step("flush20", 0, 0, 0, 1, 16'h0020, 0);
        step("drop10", 1, 16'h10, 16'h3010, 0, 0, 0);
        step("hit20", 1, 16'h20, 16'h3020, 0, 0, 1);
        chk("hit20_valid_const", 32'(id_valid), 32'h1);
        step("run_again", 1, 16'h21, 16'h3021, 0, 0, 1);
        for (int i = 0; i < 3; i++)
            step("idle2", 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            step("pre_rst", 1, 16'h50 + 16'(i), 16'h4000 + 16'(i), 0, 0, 1);
        fetch_valid = 0;
        #2 rst = 1;
        #1;
        mq.delete(); m_refill = 0; m_target = 0; m_disc = 0;
        check_all("async_rst");
        chk("async_rst.count_const", 32'(count), 32'h0);
        #1 rst = 0;
        step("post_rst", 1, 16'h60, 16'h5000, 0, 0, 0);
        step("post_rst2", 0, 0, 0, 0, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction prefetch queue between the instruction cache and the decode stage of the 16-bit pipelined core. It buffers up to DEPTH fetched instruction/PC pairs, presents the oldest to decode with a valid/stall handshake, and absorbs decode stalls without re-reading the cache. On a taken branch it flushes all buffered entries. It then discards stale in-flight cache returns until the beat carrying the branch target arrives.

## Interface
- DEPTH, 4, number of entries; power of two, at least 2.
- WIDTH, 16, instruction and PC width.
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- fetch_valid  in  1  a cache return beat is present this cycle.
- fetch_instr  in  WIDTH  instruction returned by the cache.
- fetch_pc  in  WIDTH  PC of fetch_instr.
- fetch_ready  out  1  the queue can accept a beat this cycle.
- flush  in  1  a taken branch was resolved in EX this cycle.
- flush_target  in  WIDTH  branch target PC, sampled when flush=1.
- id_valid  out  1  the head entry is valid.
- id_instr  out  WIDTH  head instruction; 16'h0000 (NOP) when id_valid=0.
- id_pc  out  WIDTH  head PC; 0 when id_valid=0.
- id_stall  in  1  decode cannot consume the head this cycle.
- count  out  log2(DEPTH)+1  number of occupied entries.
- discard_cnt  out  16  saturating count of beats dropped while refilling.

## Operation
- Storage is a circular buffer with rd_ptr and wr_ptr of log2(DEPTH) bits, which wrap modulo DEPTH, plus the count register.
- Push: fetch_valid & fetch_ready & accept, where accept is defined by the state machine below. A push writes the entry at wr_ptr, then increments wr_ptr.
- Pop: id_valid & ~id_stall. A pop increments rd_ptr.
- fetch_ready = (count != DEPTH). It is purely combinational from count and does not look at a pop in the same cycle, so a full queue never pushes.
- Push and pop together in one cycle: count is unchanged and both pointers advance.
- Head outputs are driven combinationally from the entry at rd_ptr when count != 0. Otherwise id_valid=0, id_instr=0 and id_pc=0.
- State machine, two states:
  - RUN: every beat is accepted.
  - REFILL: a beat is accepted only if fetch_pc == target_reg. A matching beat is pushed and the state returns to RUN in the same edge. A non-matching beat is dropped and discard_cnt increments, saturating at 16'hFFFF.
- flush=1, from either state:
  - At the next edge, count, rd_ptr and wr_ptr are cleared to 0.
  - target_reg is loaded with flush_target and the state goes to REFILL.
  - A push or pop in the same cycle is suppressed.
- flush while already in REFILL reloads target_reg with the new target. The queue is still empty.
- discard_cnt clears only on reset.

## Timing
- Reset values: count=0, both pointers 0, state RUN, target_reg=0, discard_cnt=0. As a result id_valid=0, id_instr=0, id_pc=0 and fetch_ready=1.
- Reset asserted mid-operation clears everything immediately, without waiting for clk. Entry contents are don't-care.
- Latency: a beat pushed at edge N is visible on the id_* outputs after edge N, i.e. in cycle N+1. There is no same-cycle bypass from fetch_* to id_*.
- The head is stable while id_stall=1. A new head appears the cycle after a pop, or id_valid drops if the queue is empty.
- Flush takes effect at the edge where it is sampled: id_valid=0 in the following cycle. The earliest valid head after a flush is two cycles after the flush cycle, when the target beat arrives in the very next cycle.
- fetch_ready falls in the cycle after the push that fills the queue. It rises in the cycle after the first pop from a full queue.
- Wrap-around: the pointer after DEPTH-1 is 0. Ordering is preserved across the wrap.

## Test plan
- Reset, then push pc=0..3 with instr 16'h1000+pc and id_stall=0 -> id_pc=0,1,2,3 on consecutive cycles, each starting the cycle after its push; count never exceeds 1.
- id_stall=1, push 5 beats (pc=0..4) -> count=4 and fetch_ready=0 after the 4th push; the 5th beat is not accepted; head stays pc=0. Release the stall -> pc 0..3 drain in order and fetch_ready=1 the cycle after the first pop.
- Fill/drain for 3×DEPTH beats with a random id_stall pattern -> output PC sequence equals input sequence, including across pointer wrap.
- With 3 entries queued, pulse flush with flush_target=16'h0040 while pushing pc=7 -> next cycle count=0 and id_valid=0. Send beats pc=8, then 9, then 0x40 -> pc=8 and 9 are dropped and discard_cnt=2; pc=0x40 is accepted and becomes the head the following cycle.
- Flush to 0x10, then flush to 0x20 one cycle later. Send a beat with pc=0x10 -> it is dropped. Send pc=0x20 -> it is accepted and the state returns to RUN.
- Assert rst asynchronously mid-cycle with count=3 -> count=0, id_valid=0, fetch_ready=1 before the next clk edge; discard_cnt=0.
